hv_bist_ctrl: RTL and testbench
===============================

HV_BIST_CTRL -- requirements
Module: hv_bist_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_M, default 48, meaning i_clk cycles per microsecond.
REQ-002 The block SHALL have parameter ABIST_TMO_US, default 100, meaning the analog BIST phase timeout in microseconds.
REQ-003 The block SHALL have parameter LBIST_TMO_US, default 500, meaning the logic BIST phase timeout in microseconds.
REQ-004 The block SHALL have these ports (name  direction  width  meaning):
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_bist_req  in  1  level; start a self-test sequence
- i_bist_abort  in  1  level; cancel the sequence in progress
- o_bist_en  out  1  enable to the analog BIST sequencer
- i_lbist_en  in  1  analog BIST sequencer finished all six items
- i_abist_status  in  6  per-item analog fail flags {adc,sc,oc,opscod,ot,ov}; 1 = fail
- o_lbist_start  out  1  single-cycle logic BIST start pulse
- i_lbist_done  in  1  logic BIST complete
- i_lbist_pass  in  1  logic BIST result, valid with i_lbist_done
- o_bist_busy  out  1  sequence in progress
- o_bist_done  out  1  single-cycle completion pulse
- o_bist_fail  out  1  overall fail
- o_bist_fail_vec  out  7  {lbist, i_abist_status[5:0]} captured fail flags
- o_bist_timeout  out  1  a phase timed out

Function
REQ-005 Timeout constants SHALL be ABIST_TMO_CYC = ABIST_TMO_US*CLK_M and LBIST_TMO_CYC = LBIST_TMO_US*CLK_M, with counter width $clog2(max(ABIST_TMO_CYC, LBIST_TMO_CYC)+1).
REQ-006 The FSM SHALL have exactly four states: IDLE, ABIST, LBIST, DONE.
REQ-007 IDLE: o_bist_en=0; if i_bist_req=1 and i_bist_abort=0, go to ABIST, clear the counter, and clear o_bist_fail_vec, o_bist_timeout and o_bist_fail.
REQ-008 ABIST: o_bist_en=1 (registered, rising the cycle after the IDLE->ABIST decision); the counter increments by 1 each cycle.
REQ-009 ABIST: when i_lbist_en=1, the block SHALL capture i_abist_status into o_bist_fail_vec[5:0], clear the counter, and go to LBIST.
REQ-010 ABIST: when i_lbist_en=0 and counter == ABIST_TMO_CYC-1, the block SHALL set o_bist_timeout=1 and go to DONE.
REQ-011 If i_lbist_en=1 on the timeout cycle, the capture SHALL win and no timeout is flagged.
REQ-012 LBIST: o_bist_en SHALL stay 1, o_lbist_start SHALL be 1 only on the first LBIST cycle, and the counter increments.
REQ-013 LBIST: when i_lbist_done=1, the block SHALL capture ~i_lbist_pass into o_bist_fail_vec[6] and go to DONE.
REQ-014 LBIST: when i_lbist_done=0 and counter == LBIST_TMO_CYC-1, the block SHALL set o_bist_timeout=1 and o_bist_fail_vec[6]=1 and go to DONE; if done and timeout coincide, done SHALL win.
REQ-015 DONE: o_bist_en=0, o_bist_done=1 for exactly this one cycle, then the FSM returns to IDLE unconditionally.
REQ-016 o_bist_fail SHALL be registered as |o_bist_fail_vec | o_bist_timeout and valid in the cycle o_bist_done=1.
REQ-017 Results SHALL hold until the next accepted i_bist_req.
REQ-018 o_bist_busy SHALL be 1 in ABIST and LBIST, and 0 in IDLE and DONE.
REQ-019 i_bist_req SHALL be ignored outside IDLE; a req held high through DONE restarts the sequence from IDLE on the next cycle.
REQ-020 i_bist_abort=1 in ABIST or LBIST SHALL return the FSM to IDLE next cycle with o_bist_en=0, no o_bist_done pulse, and all results cleared to 0.
REQ-021 i_bist_abort=1 in DONE SHALL have no effect.
REQ-022 All outputs SHALL be registered.

Reset
REQ-023 On i_rst_n=0 the block SHALL asynchronously enter IDLE, with the counter and all outputs at 0 (o_bist_fail_vec=7'h00).
REQ-024 Reset mid-sequence SHALL drop o_bist_en immediately and produce no o_bist_done pulse.

Verification
REQ-025 Pass path: req; i_lbist_en after 80 us with status 6'h00; lbist_done with pass=1 -> one done pulse, fail=0, fail_vec=7'h00, timeout=0, start pulse exactly 1 cycle.
REQ-026 ABIST fail capture: status 6'h24 at i_lbist_en; pass=0 -> fail_vec=7'h64, fail=1.
REQ-027 ABIST timeout: i_lbist_en never asserts -> done at exactly 4800 cycles after o_bist_en rise (CLK_M=48), timeout=1, fail=1, o_lbist_start never pulses.
REQ-028 Coincidence: i_lbist_done on cycle LBIST_TMO_CYC-1 with pass=1 -> timeout=0, fail=0.
REQ-029 Abort during LBIST -> IDLE, o_bist_en low next cycle, no done pulse, results 0; a subsequent req runs normally.
REQ-030 Async reset asserted in ABIST -> o_bist_en=0 and busy=0 without a clock edge.

Source files
------------

// File: rtl/hv_bist_ctrl.sv
// rtl/hv_bist_ctrl.sv - power-on self-test sequencer: analog BIST then logic BIST with per-phase timeouts
//
// Purpose: on i_bist_req, enables the analog BIST sequencer, captures its per-item fail
// flags when it finishes, fires a logic BIST start pulse, captures the logic BIST result,
// and reports a single-cycle completion with sticky results. Each phase has a watchdog.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_bist_req              level request, accepted only in IDLE
//   i_bist_abort            level abort, effective in ABIST/LBIST
//   o_bist_en               enable to the analog BIST sequencer
//   i_lbist_en              analog sequencer finished all items
//   i_abist_status[5:0]     analog per-item fail flags {adc,sc,oc,opscod,ot,ov}
//   o_lbist_start           one-cycle logic BIST start pulse
//   i_lbist_done/_pass      logic BIST completion and result
//   o_bist_busy             sequence in progress
//   o_bist_done             one-cycle completion pulse
//   o_bist_fail             overall fail
//   o_bist_fail_vec[6:0]    {lbist, analog[5:0]} captured fail flags
//   o_bist_timeout          a phase watchdog expired

`timescale 1ns/1ps

module hv_bist_ctrl #(
  parameter int CLK_M        = 48,
  parameter int ABIST_TMO_US = 100,
  parameter int LBIST_TMO_US = 500
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_bist_req,
  input  logic       i_bist_abort,
  output logic       o_bist_en,
  input  logic       i_lbist_en,
  input  logic [5:0] i_abist_status,
  output logic       o_lbist_start,
  input  logic       i_lbist_done,
  input  logic       i_lbist_pass,
  output logic       o_bist_busy,
  output logic       o_bist_done,
  output logic       o_bist_fail,
  output logic [6:0] o_bist_fail_vec,
  output logic       o_bist_timeout
);

  localparam int ABIST_TMO_CYC = ABIST_TMO_US * CLK_M;
  localparam int LBIST_TMO_CYC = LBIST_TMO_US * CLK_M;
  localparam int MAX_TMO_CYC   = (ABIST_TMO_CYC > LBIST_TMO_CYC) ? ABIST_TMO_CYC : LBIST_TMO_CYC;
  localparam int CNT_W         = $clog2(MAX_TMO_CYC + 1);

  localparam logic [CNT_W-1:0] ABIST_LAST = CNT_W'(ABIST_TMO_CYC - 1);
  localparam logic [CNT_W-1:0] LBIST_LAST = CNT_W'(LBIST_TMO_CYC - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ABIST = 2'd1;
  localparam logic [1:0] S_LBIST = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             start_q, start_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;
  logic [6:0]       vec_q, vec_d;
  logic             tmo_q, tmo_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    start_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    vec_d   = vec_q;
    tmo_d   = tmo_q;

    case (state_q)
      S_IDLE: begin
        en_d   = 1'b0;
        busy_d = 1'b0;
        if (i_bist_req && !i_bist_abort) begin
          state_d = S_ABIST;
          cnt_d   = '0;
          en_d    = 1'b1;
          busy_d  = 1'b1;
          vec_d   = '0;
          tmo_d   = 1'b0;
        end
      end

      S_ABIST: begin
        if (i_bist_abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          vec_d   = '0;
          tmo_d   = 1'b0;
        end else if (i_lbist_en) begin
          // Completion beats a coincident watchdog expiry.
          vec_d[5:0] = i_abist_status;
          cnt_d      = '0;
          state_d    = S_LBIST;
          start_d    = 1'b1;
        end else if (cnt_q == ABIST_LAST) begin
          tmo_d   = 1'b1;
          state_d = S_DONE;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_LBIST: begin
        if (i_bist_abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          vec_d   = '0;
          tmo_d   = 1'b0;
        end else if (i_lbist_done) begin
          vec_d[6] = ~i_lbist_pass;
          state_d  = S_DONE;
          en_d     = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end else if (cnt_q == LBIST_LAST) begin
          // A logic BIST that never reports is treated as a logic BIST failure.
          vec_d[6] = 1'b1;
          tmo_d    = 1'b1;
          state_d  = S_DONE;
          en_d     = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        // DONE lasts one cycle; abort and req are both ignored here.
        state_d = S_IDLE;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // Built from next-state values so the flag lines up with the done pulse.
    fail_d = (|vec_d) | tmo_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      vec_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      vec_q   <= vec_d;
      tmo_q   <= tmo_d;
    end
  end

  assign o_bist_en       = en_q;
  assign o_lbist_start   = start_q;
  assign o_bist_busy     = busy_q;
  assign o_bist_done     = done_q;
  assign o_bist_fail     = fail_q;
  assign o_bist_fail_vec = vec_q;
  assign o_bist_timeout  = tmo_q;

endmodule

// File: tb/tb_hv_bist_ctrl.sv
// tb/tb_hv_bist_ctrl.sv - directed self-checking bench for hv_bist_ctrl

`timescale 1ns/1ps

module tb_hv_bist_ctrl;

  localparam int CLK_M         = 48;
  localparam int ABIST_TMO_CYC = 100 * CLK_M;
  localparam int LBIST_TMO_CYC = 500 * CLK_M;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic       abort = 1'b0;
  logic       lbist_en = 1'b0;
  logic [5:0] status = 6'h00;
  logic       lbist_done = 1'b0;
  logic       lbist_pass = 1'b0;
  logic       bist_en, lbist_start, busy, done, fail, timeout;
  logic [6:0] fail_vec;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int start_cnt = 0;
  int cyc;

  always #5 clk = ~clk;

  hv_bist_ctrl #(.CLK_M(CLK_M), .ABIST_TMO_US(100), .LBIST_TMO_US(500)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_bist_req     (req),
    .i_bist_abort   (abort),
    .o_bist_en      (bist_en),
    .i_lbist_en     (lbist_en),
    .i_abist_status (status),
    .o_lbist_start  (lbist_start),
    .i_lbist_done   (lbist_done),
    .i_lbist_pass   (lbist_pass),
    .o_bist_busy    (busy),
    .o_bist_done    (done),
    .o_bist_fail    (fail),
    .o_bist_fail_vec(fail_vec),
    .o_bist_timeout (timeout)
  );

  // Pulse counters sampled mid-cycle, clear of the active edge.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (lbist_start) start_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_seq();
    req = 1'b1;
    step();
    req = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output int n);
    n = 0;
    while (!done && n < max_cyc) begin
      step();
      n++;
    end
    if (!done) chk("wait_done_bound", 32'(done), 32'd1);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_en", 32'(bist_en), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_fail", 32'(fail), 0);
    chk("rst_vec", 32'(fail_vec), 0);
    chk("rst_tmo", 32'(timeout), 0);
    chk("rst_start", 32'(lbist_start), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Pass path
    done_cnt = 0; start_cnt = 0;
    start_seq();
    chk("pass_en_rise", 32'(bist_en), 1);
    chk("pass_busy", 32'(busy), 1);
    repeat (80 * CLK_M) step();
    lbist_en = 1'b1; status = 6'h00;
    step();
    lbist_en = 1'b0;
    chk("pass_start", 32'(lbist_start), 1);
    chk("pass_en_lbist", 32'(bist_en), 1);
    repeat (20) step();
    lbist_done = 1'b1; lbist_pass = 1'b1;
    step();
    lbist_done = 1'b0;
    chk("pass_done", 32'(done), 1);
    chk("pass_fail", 32'(fail), 0);
    chk("pass_vec", 32'(fail_vec), 7'h00);
    chk("pass_tmo", 32'(timeout), 0);
    chk("pass_en_done", 32'(bist_en), 0);
    chk("pass_busy_done", 32'(busy), 0);
    repeat (3) step();
    chk("pass_done_cnt", 32'(done_cnt), 1);
    chk("pass_start_cnt", 32'(start_cnt), 1);

    // Analog fail capture plus logic BIST fail
    start_seq();
    repeat (10) step();
    lbist_en = 1'b1; status = 6'h24;
    step();
    lbist_en = 1'b0; status = 6'h00;
    repeat (5) step();
    lbist_done = 1'b1; lbist_pass = 1'b0;
    step();
    lbist_done = 1'b0;
    chk("cap_done", 32'(done), 1);
    chk("cap_vec", 32'(fail_vec), 7'h64);
    chk("cap_fail", 32'(fail), 1);
    chk("cap_tmo", 32'(timeout), 0);
    repeat (4) step();
    chk("cap_vec_hold", 32'(fail_vec), 7'h64);
    chk("cap_fail_hold", 32'(fail), 1);

    // Analog phase timeout: done exactly ABIST_TMO_CYC cycles after en rises
    start_cnt = 0;
    start_seq();
    chk("atmo_en_rise", 32'(bist_en), 1);
    wait_done(ABIST_TMO_CYC + 100, cyc);
    chk("atmo_latency", 32'(cyc), 32'(ABIST_TMO_CYC));
    chk("atmo_tmo", 32'(timeout), 1);
    chk("atmo_fail", 32'(fail), 1);
    chk("atmo_vec", 32'(fail_vec), 7'h00);
    chk("atmo_start_cnt", 32'(start_cnt), 0);
    step();

    // Logic phase timeout
    start_seq();
    lbist_en = 1'b1; status = 6'h01;
    step();
    lbist_en = 1'b0; status = 6'h00;
    repeat (LBIST_TMO_CYC - 1) step();
    chk("ltmo_not_yet", 32'(done), 0);
    step();
    chk("ltmo_done", 32'(done), 1);
    chk("ltmo_tmo", 32'(timeout), 1);
    chk("ltmo_vec", 32'(fail_vec), 7'h41);
    chk("ltmo_fail", 32'(fail), 1);
    step();

    // Done coincides with logic timeout: done wins
    start_seq();
    lbist_en = 1'b1;
    step();
    lbist_en = 1'b0;
    repeat (LBIST_TMO_CYC - 1) step();
    lbist_done = 1'b1; lbist_pass = 1'b1;
    step();
    lbist_done = 1'b0;
    chk("coin_done", 32'(done), 1);
    chk("coin_tmo", 32'(timeout), 0);
    chk("coin_fail", 32'(fail), 0);
    chk("coin_vec", 32'(fail_vec), 7'h00);
    step();

    // Abort during LBIST
    done_cnt = 0;
    start_seq();
    repeat (3) step();
    lbist_en = 1'b1; status = 6'h3f;
    step();
    lbist_en = 1'b0; status = 6'h00;
    repeat (2) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_en", 32'(bist_en), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_vec", 32'(fail_vec), 7'h00);
    chk("abort_fail", 32'(fail), 0);
    chk("abort_tmo", 32'(timeout), 0);
    repeat (5) step();
    chk("abort_no_done", 32'(done_cnt), 0);
    start_seq();
    repeat (3) step();
    lbist_en = 1'b1; status = 6'h02;
    step();
    lbist_en = 1'b0; status = 6'h00;
    lbist_done = 1'b1; lbist_pass = 1'b1;
    step();
    lbist_done = 1'b0;
    chk("rerun_done", 32'(done), 1);
    chk("rerun_vec", 32'(fail_vec), 7'h02);
    chk("rerun_fail", 32'(fail), 1);
    step();

    // Asynchronous reset while in ABIST
    done_cnt = 0;
    start_seq();
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_en", 32'(bist_en), 0);
    chk("arst_busy", 32'(busy), 0);
    #3;
    rst_n = 1'b1;
    repeat (5) step();
    chk("arst_no_done", 32'(done_cnt), 0);
    chk("arst_idle_busy", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
